uart_boot_loader: RTL and testbench
===================================

// Module: uart_boot_loader
// PURPOSE
//  Controller for the UART RX byte buffer, a 512x8 RAM with a 1-cycle synchronous read.
//  On start or buffer-full it drains the captured bytes and packs them little-endian into 32-bit words.
//  It writes those words into instruction memory, then pulses rx_fifo_full_ack to rearm the receiver.
//  It also shares the buffer read port with CPU MMIO byte reads; the CPU always wins.
// PARAMETERS
//  MEM_AW     7      instruction-memory word-address width (128 words = 512 bytes)
//  BASE_WA    0      first instruction-memory word address written
// PORTS
//  clk           in   1    system clock
//  reset         in   1    synchronous, active-high reset
//  start         in   1    1-cycle pulse: copy rx_fifo_wa bytes now
//  rx_fifo_full  in   1    receiver buffer full (512 bytes); auto-starts a copy
//  rx_fifo_wa    in   9    receiver write pointer = bytes captured (0..511)
//  rx_fifo_full_ack out 1  1-cycle pulse at end of copy; receiver resets its pointer
//  buf_ren       out  1    buffer read enable
//  buf_ra        out  9    buffer read address
//  buf_rd        in   8    buffer read data, valid the cycle after buf_ren
//  cpu_req       in   1    CPU byte-read request (level, held until cpu_gnt)
//  cpu_addr      in   9    CPU byte address
//  cpu_gnt       out  1    request accepted this cycle (combinational)
//  cpu_rvalid    out  1    cpu_rdata valid (cycle after cpu_gnt)
//  cpu_rdata     out  8    CPU read data
//  mem_wen       out  1    instruction-memory write strobe (1 cycle per word)
//  mem_wa        out  MEM_AW word address
//  mem_wd        out  32   packed word, byte0 in [7:0]
//  busy          out  1    copy in progress
//  done          out  1    sticky, set with rx_fifo_full_ack; cleared by next start/auto-start
//  checksum      out  8    mod-256 sum of copied bytes (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte counter, word register, and in-flight owner flag cleared.
//  Length: latched at trigger. The start pulse latches rx_fifo_wa. An rx_fifo_full edge latches 512.
//    Length 0 skips straight to ACK.
//  Triggers are ignored while busy. If start and rx_fifo_full are both present in IDLE, full wins (length 512).
//  Arbitration: per cycle, cpu_req=1 -> cpu_gnt=1, buf_ra=cpu_addr, and the engine does not issue.
//    Any in-flight engine read still completes.
//  Owner flag records who issued each read. buf_rd routes to cpu_rdata (cpu_rvalid=1) or to the packer.
//  FSM:
//   IDLE -> RD on trigger (busy=1, done=0).
//   RD: issue a read of byte n when not preempted -> CAP.
//   CAP: place buf_rd in lane n[1:0] and increment n.
//     If lane 3 was filled or n==length -> WR; else -> RD.
//   WR: mem_wen=1, mem_wa=BASE_WA+n_word; unfilled lanes of the last word are 0x00.
//     Then -> RD if n<length, else -> ACK.
//   ACK: rx_fifo_full_ack=1 for exactly 1 cycle, done=1 -> IDLE (busy=0).
//  Throughput: 2 cycles/byte + 1 cycle/word with no CPU contention.
//    A full 512-byte copy is 1024+128+2 cycles from trigger to ack.
//  mem_wa wraps modulo 2^MEM_AW; no error is flagged.
//  Reset mid-copy aborts immediately: no ack is issued and no partial word is written.
//  A CPU read during a copy returns buffer contents, not copy progress.
// CONFIGURATION
//  UART_BOOT_CHECKSUM_EN defined:
//    checksum accumulates each byte captured in CAP, mod 256.
//    It is cleared on trigger and held after ACK until the next trigger.
//  Not defined: checksum is tied to 8'h00 and the accumulator is not built.
// TESTING
//  1. start with rx_fifo_wa=8, bytes 01..08 -> 2 writes: wa0=32'h04030201, wa1=32'h08070605.
//     Then 1 ack pulse, done=1; checksum=8'h24 (if EN).
//  2. rx_fifo_wa=5, bytes AA BB CC DD EE, start -> writes 32'hDDCCBBAA, then 32'h000000EE; 1 ack.
//  3. rx_fifo_full=1 with a 512-byte ramp 00..FF,00..FF.
//     -> 128 writes, last word 32'hFFFEFDFC at wa 127; ack 1154 cycles after full.
//  4. cpu_req held 10 cycles mid-copy at addr 9'h010.
//     -> cpu_gnt each cycle, cpu_rdata = byte[16] each following cycle.
//     Copy stalls 10 cycles; packed data unchanged vs. scenario 1.
//  5. start with rx_fifo_wa=0 -> no mem_wen; ack 2 cycles after start.
//  6. reset asserted in cycle 20 of a 512-byte copy.
//     -> next cycle busy=0, no ack, no further mem_wen; a new start copies correctly.

Source files
------------

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: drains the UART RX byte buffer into instruction memory as little-endian words.
// Define UART_BOOT_CHECKSUM_EN to build the mod-256 checksum of copied bytes.
module uart_boot_loader #(
    parameter int unsigned MEM_AW  = 7,
    parameter int unsigned BASE_WA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_fifo_full,
    input  logic [8:0]        rx_fifo_wa,
    output logic              rx_fifo_full_ack,
    output logic              buf_ren,
    output logic [8:0]        buf_ra,
    input  logic [7:0]        buf_rd,
    input  logic              cpu_req,
    input  logic [8:0]        cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [7:0]        cpu_rdata,
    output logic              mem_wen,
    output logic [MEM_AW-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);
    localparam int unsigned BUF_AW   = 9;
    localparam int unsigned LEN_W    = 10;
    localparam int unsigned FULL_LEN = 512;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, ACK} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  n_q, n_d, len_q, len_d, n_inc;
    logic [31:0]       word_q, word_d, word_nxt;
    logic [MEM_AW-1:0] widx_q, widx_d, mem_wa_q, mem_wa_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic              mem_wen_q, mem_wen_d, ack_q, ack_d, done_q, done_d;
    logic              busy_q, busy_d, own_cpu_q, own_cpu_d, full_prev_q, full_prev_d;
    logic              trig_full;
    logic [1:0]        lane;

    assign trig_full = rx_fifo_full && !full_prev_q;

    // Next-state, packer and read-port arbitration; the CPU always owns the port when requesting.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        len_d       = len_q;
        word_d      = word_q;
        widx_d      = widx_q;
        mem_wen_d   = 1'b0;
        mem_wa_d    = mem_wa_q;
        mem_wd_d    = mem_wd_q;
        ack_d       = 1'b0;
        done_d      = done_q;
        full_prev_d = rx_fifo_full;
        own_cpu_d   = cpu_req;
        cpu_gnt     = cpu_req;
        buf_ren     = cpu_req;
        buf_ra      = '0;
        word_nxt    = word_q;
        n_inc       = n_q + LEN_W'(1);
        lane        = n_q[1:0];
        if (cpu_req) begin
            buf_ra = cpu_addr;
        end
        case (state_q)
            IDLE: begin
                if (trig_full || start) begin
                    len_d  = trig_full ? LEN_W'(FULL_LEN) : LEN_W'(rx_fifo_wa);
                    n_d    = '0;
                    word_d = '0;
                    widx_d = '0;
                    done_d = 1'b0;
                    state_d = (len_d == '0) ? ACK : RD;
                end
            end
            RD: begin
                if (!cpu_req) begin
                    buf_ren = 1'b1;
                    buf_ra  = n_q[BUF_AW-1:0];
                    state_d = CAP;
                end
            end
            CAP: begin
                word_nxt[{lane, 3'b000} +: 8] = buf_rd;
                n_d = n_inc;
                if (lane == 2'd3 || n_inc == len_q) begin
                    mem_wen_d = 1'b1;
                    mem_wa_d  = MEM_AW'(BASE_WA) + widx_q;
                    mem_wd_d  = word_nxt;
                    word_d    = '0;
                    state_d   = WR;
                end else begin
                    word_d  = word_nxt;
                    state_d = RD;
                end
            end
            WR: begin
                widx_d  = widx_q + MEM_AW'(1);
                state_d = (n_q < len_q) ? RD : ACK;
            end
            ACK: begin
                ack_d   = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            len_q       <= '0;
            word_q      <= '0;
            widx_q      <= '0;
            mem_wen_q   <= 1'b0;
            mem_wa_q    <= '0;
            mem_wd_q    <= '0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            own_cpu_q   <= 1'b0;
            full_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            len_q       <= len_d;
            word_q      <= word_d;
            widx_q      <= widx_d;
            mem_wen_q   <= mem_wen_d;
            mem_wa_q    <= mem_wa_d;
            mem_wd_q    <= mem_wd_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            own_cpu_q   <= own_cpu_d;
            full_prev_q <= full_prev_d;
        end
    end

    assign rx_fifo_full_ack = ack_q;
    assign mem_wen          = mem_wen_q;
    assign mem_wa           = mem_wa_q;
    assign mem_wd           = mem_wd_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign cpu_rvalid       = own_cpu_q;
    // Read data lands one cycle after issue, so it is steered by who issued last cycle.
    assign cpu_rdata        = own_cpu_q ? buf_rd : 8'h00;

`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       trig_go, cap_en;

    assign trig_go = (state_q == IDLE) && (trig_full || start);
    assign cap_en  = (state_q == CAP);

    always_comb begin
        csum_d = csum_q;
        if (trig_go) begin
            csum_d = 8'h00;
        end else if (cap_en) begin
            csum_d = csum_q + buf_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: table-driven and randomized copies against a byte-level reference model.
module tb_uart_boot_loader;
    localparam int unsigned MEM_AW  = 7;
    localparam int unsigned BASE_WA = 0;

    logic              clk = 1'b0;
    logic              reset, start, rx_fifo_full, rx_fifo_full_ack, buf_ren;
    logic              cpu_req, cpu_gnt, cpu_rvalid, mem_wen, busy, done;
    logic [8:0]        rx_fifo_wa, buf_ra, cpu_addr;
    logic [7:0]        buf_rd, cpu_rdata, checksum;
    logic [MEM_AW-1:0] mem_wa;
    logic [31:0]       mem_wd;

    uart_boot_loader #(.MEM_AW(MEM_AW), .BASE_WA(BASE_WA)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_fifo_full(rx_fifo_full),
        .rx_fifo_wa(rx_fifo_wa), .rx_fifo_full_ack(rx_fifo_full_ack),
        .buf_ren(buf_ren), .buf_ra(buf_ra), .buf_rd(buf_rd),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .busy(busy), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // RX byte buffer: 512x8 with one-cycle synchronous read
    logic [7:0] ram [512];
    logic [7:0] ram_rd = 8'h00;
    always @(posedge clk) if (buf_ren) ram_rd <= ram[buf_ra];
    assign buf_rd = ram_rd;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [MEM_AW-1:0] wa_log[$];
    logic [31:0]       wd_log[$];
    int                ack_total = 0;
    always @(negedge clk) begin
        if (mem_wen) begin
            wa_log.push_back(mem_wa);
            wd_log.push_back(mem_wd);
        end
        if (rx_fifo_full_ack) ack_total <= ack_total + 1;
    end

    int          n_pass = 0;
    int          n_chk  = 0;
    int unsigned t0;
    int          ack_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 512; i++) begin
            case (pat)
                0:       ram[i] = 8'(i);
                1:       ram[i] = 8'(i + 1);
                2:       ram[i] = 8'(170 + 17 * i);
                default: ram[i] = 8'($urandom);
            endcase
        end
    endtask

    function automatic logic [31:0] model_word(input int w, input int len);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < len) r = r | (32'(ram[4 * w + b]) << (8 * b));
        return r;
    endfunction

    function automatic logic [7:0] model_sum(input int len);
        int s;
        s = 0;
        for (int i = 0; i < len; i++) s += int'(ram[i]);
        return 8'(s);
    endfunction

    function automatic int model_lat(input int len);
        return 2 * len + (len + 3) / 4 + 2;
    endfunction

    // trig: 0 = start pulse, 1 = rx_fifo_full, 2 = both together
    task automatic trigger(input int len, input int trig);
        @(negedge clk);
        wa_log.delete();
        wd_log.delete();
        ack_base     = ack_total;
        rx_fifo_wa   = 9'(len);
        start        = (trig != 1);
        rx_fifo_full = (trig != 0);
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_trigger", 32'(busy), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
    endtask

    task automatic wait_ack(input bit noise, input int bound, output int lat);
        bit         pend;
        logic [8:0] pend_addr;
        lat  = -1;
        pend = 1'b0;
        pend_addr = '0;
        for (int k = 0; k < bound && lat < 0; k++) begin
            if (pend) begin
                chk("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
                chk("cpu_rdata", 32'(cpu_rdata), 32'(ram[pend_addr]));
            end
            pend    = 1'b0;
            cpu_req = 1'b0;
            if (rx_fifo_full_ack) begin
                lat = int'(cyc - t0);
                rx_fifo_full = 1'b0;
                chk("done_at_ack", 32'(done), 32'd1);
                chk("busy_at_ack", 32'(busy), 32'd0);
            end else if (noise && $urandom_range(2) == 0) begin
                cpu_req  = 1'b1;
                cpu_addr = 9'($urandom_range(511));
                #1;
                chk("cpu_gnt", 32'(cpu_gnt), 32'd1);
                chk("buf_ra_cpu", 32'(buf_ra), 32'(cpu_addr));
                pend = 1'b1;
                pend_addr = cpu_addr;
            end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        if (lat < 0) begin
            n_chk++;
            rx_fifo_full = 1'b0;
            $display("FAIL ack_timeout: no ack within %0d cycles", bound);
        end
    endtask

    task automatic check_result(input string tag, input int len, input int lat, input bit use_lat);
        int nw;
        nw = (len + 3) / 4;
        repeat (3) @(negedge clk);
        if (use_lat) chk({tag, "_latency"}, 32'(lat), 32'(model_lat(len)));
        chk({tag, "_ack_pulses"}, 32'(ack_total - ack_base), 32'd1);
        chk({tag, "_word_count"}, 32'(wd_log.size()), 32'(nw));
        for (int w = 0; w < nw && w < wd_log.size(); w++) begin
            chk({tag, "_wa"}, 32'(wa_log[w]), 32'((BASE_WA + w) % (1 << MEM_AW)));
            chk({tag, "_wd"}, wd_log[w], model_word(w, len));
        end
`ifdef UART_BOOT_CHECKSUM_EN
        chk({tag, "_checksum"}, 32'(checksum), 32'(model_sum(len)));
`else
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    typedef struct {
        int          len;
        int          trig;
        int          pat;
        int          nw;
        logic [31:0] first_w;
        logic [31:0] last_w;
        int          lat;
        logic [7:0]  sum;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   lat;
        int   len;

        vecs[0] = '{8,   0, 1, 2,   32'h04030201, 32'h08070605, 20,   8'h24};
        vecs[1] = '{5,   0, 2, 2,   32'hDDCCBBAA, 32'h000000EE, 14,   8'hFC};
        vecs[2] = '{512, 1, 0, 128, 32'h03020100, 32'hFFFEFDFC, 1154, 8'h00};
        vecs[3] = '{0,   0, 1, 0,   32'h0,        32'h0,        2,    8'h00};
        vecs[4] = '{1,   0, 1, 1,   32'h00000001, 32'h00000001, 5,    8'h01};
        vecs[5] = '{4,   0, 1, 1,   32'h04030201, 32'h04030201, 11,   8'h0A};
        vecs[6] = '{9,   0, 1, 3,   32'h04030201, 32'h00000009, 23,   8'h2D};
        vecs[7] = '{512, 2, 0, 128, 32'h03020100, 32'hFFFEFDFC, 1154, 8'h00};

        reset = 1'b1; start = 1'b0; rx_fifo_full = 1'b0; rx_fifo_wa = '0;
        cpu_req = 1'b0; cpu_addr = '0;
        fill(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack", 32'(rx_fifo_full_ack), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_wa", 32'(mem_wa), 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ren", 32'(buf_ren), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].pat);
            trigger(vecs[v].len, vecs[v].trig);
            wait_ack(1'b0, vecs[v].lat + 60, lat);
            check_result($sformatf("vec%0d", v), vecs[v].len, lat, 1'b1);
            chk($sformatf("vec%0d_tbl_lat", v), 32'(lat), 32'(vecs[v].lat));
            chk($sformatf("vec%0d_tbl_nw", v), 32'(wd_log.size()), 32'(vecs[v].nw));
            if (vecs[v].nw > 0 && wd_log.size() >= vecs[v].nw) begin
                chk($sformatf("vec%0d_tbl_first", v), wd_log[0], vecs[v].first_w);
                chk($sformatf("vec%0d_tbl_last", v), wd_log[vecs[v].nw - 1], vecs[v].last_w);
            end
`ifdef UART_BOOT_CHECKSUM_EN
            chk($sformatf("vec%0d_tbl_sum", v), 32'(checksum), 32'(vecs[v].sum));
`endif
        end

        // CPU holds the port for 10 cycles starting in a read slot: copy stalls exactly 10
        fill(1);
        trigger(8, 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            cpu_req  = 1'b1;
            cpu_addr = 9'h010;
            #1;
            chk("hold_gnt", 32'(cpu_gnt), 32'd1);
            if (i > 0) begin
                chk("hold_rvalid", 32'(cpu_rvalid), 32'd1);
                chk("hold_rdata", 32'(cpu_rdata), 32'h11);
            end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        chk("hold_rvalid_last", 32'(cpu_rvalid), 32'd1);
        chk("hold_rdata_last", 32'(cpu_rdata), 32'h11);
        @(negedge clk);
        wait_ack(1'b0, 100, lat);
        check_result("cpu_hold", 8, lat, 1'b0);
        chk("cpu_hold_latency", 32'(lat), 32'd30);

        // Triggers arriving mid-copy are ignored
        fill(1);
        trigger(8, 0);
        @(negedge clk);
        start = 1'b1; rx_fifo_wa = 9'd3; rx_fifo_full = 1'b1;
        @(negedge clk);
        start = 1'b0; rx_fifo_full = 1'b0;
        wait_ack(1'b0, 100, lat);
        check_result("busy_ignore", 8, lat, 1'b1);

        // Reset in cycle 20 of a full copy aborts with no ack and no further writes
        fill(0);
        trigger(512, 1);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        rx_fifo_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(rx_fifo_full_ack), 32'd0);
        chk("abort_wen", 32'(mem_wen), 32'd0);
        wa_log.delete();
        wd_log.delete();
        ack_base = ack_total;
        repeat (30) @(negedge clk);
        chk("abort_no_writes", 32'(wd_log.size()), 32'd0);
        chk("abort_no_ack", 32'(ack_total - ack_base), 32'd0);
        fill(3);
        trigger(13, 0);
        wait_ack(1'b0, 100, lat);
        check_result("after_abort", 13, lat, 1'b1);

        // Random lengths and contents with random CPU reads interleaved
        for (int r = 0; r < 6; r++) begin
            len = (r == 5) ? 300 : int'($urandom_range(60, 1));
            fill(3);
            trigger(len, 0);
            wait_ack(1'b1, 4 * model_lat(len) + 100, lat);
            check_result($sformatf("rand%0d", r), len, lat, 1'b0);
            chk($sformatf("rand%0d_lat_floor", r), 32'(lat >= model_lat(len)), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
